ul8_cpu_core: RTL and testbench

UL8_CPU_CORE -- requirements
Module: ul8_cpu_core

---
 rtl/ul8_cpu_core.sv | 148 ++++++++++++++
 tb/tb_ul8_cpu_core.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ul8_cpu_core.sv
// ul8_cpu_core: accumulator CPU with on-chip RAM, program load port, 3-tick instruction cycle.
// Build option UL8_STEP_EN adds step_mode/step inputs and a WAIT state after EXECUTE.
module ul8_cpu_core #(
   parameter int    DATA_W    = 8,
   parameter int    ADDR_W    = 5,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              tick,
   input  logic              startn,
`ifdef UL8_STEP_EN
   input  logic              step_mode,
   input  logic              step,
`endif
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] akku,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [2:0]        state,
   output logic              busy,
   output logic              halted
);

   localparam logic [2:0] S_IDLE    = 3'b000;
   localparam logic [2:0] S_FETCH   = 3'b001;
   localparam logic [2:0] S_DECODE  = 3'b010;
   localparam logic [2:0] S_EXECUTE = 3'b011;
`ifdef UL8_STEP_EN
   localparam logic [2:0] S_WAIT    = 3'b100;
`endif
   localparam logic [2:0] S_HALT    = 3'b101;

   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

   logic [DATA_W-1:0] r_ram [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] r_akku;
   logic [DATA_W-1:0] r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_operand;
   logic [2:0]        r_state;
   logic              r_startn;
   logic              r_pending;

   logic              w_start_evt;
   logic              w_parked;
   logic              w_consume;
   logic              w_ld_ok;
   logic              w_stv;
   logic [2:0]        w_opcode;
   logic [2:0]        w_after_exec;
   logic [DATA_W-1:0] w_mem;

   assign w_opcode    = r_ir[DATA_W-1 -: 3];
   assign w_mem       = r_ram[r_operand];
   assign w_start_evt = r_startn & ~startn;
   assign w_parked    = (r_state == S_IDLE) || (r_state == S_HALT);
   assign w_consume   = tick && r_pending && w_parked;
   assign w_ld_ok     = ld_we && w_parked;
   assign w_stv       = tick && (r_state == S_EXECUTE) && (w_opcode == 3'b001);

`ifdef UL8_STEP_EN
   assign w_after_exec = step_mode ? S_WAIT : S_FETCH;
`else
   assign w_after_exec = S_FETCH;
`endif

   // RAM has no reset so a loaded program survives resetn
   always_ff @(posedge clk) begin
      if (w_ld_ok) begin
         r_ram[ld_addr] <= ld_data;
      end else if (w_stv) begin
         r_ram[r_operand] <= r_akku;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_akku    <= '0;
         r_ir      <= '0;
         r_operand <= '0;
         r_pending <= 1'b0;
         r_startn  <= 1'b1;
      end else begin
         r_startn <= startn;
         if (w_start_evt) begin
            r_pending <= 1'b1;
         end else if (w_consume) begin
            r_pending <= 1'b0;
         end
         if (tick) begin
            case (r_state)
               S_IDLE: begin
                  if (r_pending) r_state <= S_FETCH;
               end
               S_FETCH: begin
                  r_ir    <= r_ram[r_pc];
                  r_state <= S_DECODE;
               end
               S_DECODE: begin
                  r_pc      <= r_pc + PC_ONE;
                  r_operand <= r_ir[ADDR_W-1:0];
                  r_state   <= S_EXECUTE;
               end
               S_EXECUTE: begin
                  r_state <= w_after_exec;
                  case (w_opcode)
                     3'b000:  r_akku <= w_mem;
                     3'b010:  r_akku <= r_akku + w_mem;
                     3'b011:  r_akku <= ~(r_akku & w_mem);
                     3'b100:  r_pc <= r_operand;
                     3'b101:  if (r_akku[DATA_W-1]) r_pc <= r_operand;
                     3'b110:  r_akku <= ~r_akku;
                     3'b111:  r_state <= S_HALT;
                     default: ;
                  endcase
               end
`ifdef UL8_STEP_EN
               S_WAIT: begin
                  if (step) r_state <= S_FETCH;
               end
`endif
               S_HALT: begin
                  if (r_pending) begin
                     r_pc    <= '0;
                     r_akku  <= '0;
                     r_ir    <= '0;
                     r_state <= S_FETCH;
                  end
               end
               default: r_state <= S_HALT;
            endcase
         end
      end
   end

   assign akku   = r_akku;
   assign pc     = r_pc;
   assign ir     = r_ir;
   assign state  = r_state;
   assign busy   = ~w_parked;
   assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_ul8_cpu_core.sv
// tb_ul8_cpu_core: directed programs checked against an instruction-level model.
// Also runs a 12-bit/9-bit build of the core on the same sum program.
module tb_ul8_cpu_core;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       tick = 1'b1;
   logic       startn = 1'b1;
   logic       ld_we = 1'b0;
   logic [4:0] ld_addr = '0;
   logic [7:0] ld_data = '0;
   logic [7:0] akku;
   logic [4:0] pc;
   logic [7:0] ir;
   logic [2:0] state;
   logic       busy;
   logic       halted;
`ifdef UL8_STEP_EN
   logic       step_mode = 1'b0;
   logic       step = 1'b0;
`endif

   logic        startn2 = 1'b1;
   logic        ld_we2 = 1'b0;
   logic [8:0]  ld_addr2 = '0;
   logic [11:0] ld_data2 = '0;
   logic [11:0] akku2;
   logic [8:0]  pc2;
   logic [11:0] ir2;
   logic [2:0]  state2;
   logic        busy2;
   logic        halted2;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] m_ram [32];
   logic [7:0] m_acc;
   logic [7:0] m_ir;
   logic [4:0] m_pc;
   bit         m_halt = 0;
   bit         m_run = 0;
   int         m_ph = 0;
   int         m_ticks = 0;

   ul8_cpu_core u_dut (
      .clk(clk), .resetn(resetn), .tick(tick), .startn(startn),
`ifdef UL8_STEP_EN
      .step_mode(step_mode), .step(step),
`endif
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .akku(akku), .pc(pc), .ir(ir), .state(state),
      .busy(busy), .halted(halted)
   );

   ul8_cpu_core #(.DATA_W(12), .ADDR_W(9)) u_dut12 (
      .clk(clk), .resetn(resetn), .tick(tick), .startn(startn2),
`ifdef UL8_STEP_EN
      .step_mode(1'b0), .step(1'b0),
`endif
      .ld_we(ld_we2), .ld_addr(ld_addr2), .ld_data(ld_data2),
      .akku(akku2), .pc(pc2), .ir(ir2), .state(state2),
      .busy(busy2), .halted(halted2)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // one whole instruction at ISA level
   task automatic m_exec();
      logic [7:0] w;
      logic [4:0] a;
      w = m_ram[m_pc];
      a = w[4:0];
      m_ir = w;
      m_pc = m_pc + 5'd1;
      case (w[7:5])
         3'd0: m_acc = m_ram[a];
         3'd1: m_ram[a] = m_acc;
         3'd2: m_acc = m_acc + m_ram[a];
         3'd3: m_acc = ~(m_acc & m_ram[a]);
         3'd4: m_pc = a;
         3'd5: if (m_acc[7]) m_pc = a;
         3'd6: m_acc = ~m_acc;
         default: m_halt = 1;
      endcase
   endtask

   // a clock edge; the model counts ticks and retires an instruction every third
   task automatic cyc();
      @(posedge clk);
      if (m_run && tick && !m_halt) begin
         m_ticks++;
         if (m_ph == 2) begin
            m_exec();
            m_ph = 0;
         end else begin
            m_ph++;
         end
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (m_run) begin
         chk("state", state, m_halt ? 32'd5 : 32'(m_ph + 1));
         chk("busy", busy, !m_halt);
         chk("halted", halted, m_halt);
         if (m_ph == 0) begin
            chk("akku", akku, m_acc);
            chk("pc", pc, m_pc);
            chk("ir", ir, m_ir);
         end
      end
   end

   task automatic ld(input logic [4:0] a, input logic [7:0] d);
      @(posedge clk);
      #1 ld_we = 1; ld_addr = a; ld_data = d; m_ram[a] = d;
      @(posedge clk);
      #1 ld_we = 0;
   endtask

   task automatic ld2(input logic [8:0] a, input logic [11:0] d);
      @(posedge clk);
      #1 ld_we2 = 1; ld_addr2 = a; ld_data2 = d;
      @(posedge clk);
      #1 ld_we2 = 0;
   endtask

   // ldmode 1: load word alongside start; ldmode 2: load attempt during first FETCH
   task automatic start_core(input int ldmode, input logic [4:0] la, input logic [7:0] ldd);
      @(posedge clk);
      #1 startn = 0; tick = 1;
      if (ldmode == 1) begin
         ld_we = 1; ld_addr = la; ld_data = ldd; m_ram[la] = ldd;
      end
      @(posedge clk);
      #1 ld_we = 0;
      @(posedge clk);
      #1 startn = 1;
      m_ph = 0; m_halt = 0; m_pc = 0; m_acc = 0; m_ir = 0; m_ticks = 0; m_run = 1;
      if (ldmode == 2) begin
         ld_we = 1; ld_addr = la; ld_data = ldd;
      end
   endtask

   task automatic run_prog(input bit gate, input int ldmode, input logic [4:0] la, input logic [7:0] ldd);
      start_core(ldmode, la, ldd);
      for (int c = 0; c < 400 && !m_halt; c++) begin
         cyc();
         ld_we = 0;
         tick = gate ? ((c % 4) != 3) : 1'b1;
      end
      chk("run_done", m_halt, 1);
      @(negedge clk);
      #1 m_run = 0; tick = 1;
   endtask

   initial begin
      #3;
      chk("rst_state", state, 0);
      chk("rst_pc", pc, 0);
      chk("rst_akku", akku, 0);
      chk("rst_ir", ir, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1;

      // wide build: 100+200 stored at 302
      ld2(9'd0, 12'h12C); ld2(9'd1, 12'h52D); ld2(9'd2, 12'h32E);
      ld2(9'd3, 12'hE00); ld2(9'd300, 12'd100); ld2(9'd301, 12'd200);
      @(posedge clk);
      #1 startn2 = 0;
      @(posedge clk);
      @(posedge clk);
      #1 startn2 = 1;
      @(negedge clk);
      chk("w12_fetch", state2, 1);
      begin
         int n;
         n = 0;
         while (!halted2 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
         end
         chk("w12_ticks", n, 12);
      end
      chk("w12_akku", akku2, 300);
      chk("w12_pc", pc2, 4);
      chk("w12_ram302", u_dut12.r_ram[302], 300);

      // LDA 20, ADD 21, STV 22, HLT; FETCH-time write to 21 must be dropped
      ld(0, 8'h14); ld(1, 8'h55); ld(2, 8'h36); ld(3, 8'hE0);
      ld(20, 8'd100); ld(21, 8'd200); ld(22, 8'h00);
      run_prog(0, 2, 5'd21, 8'h55);
      chk("p1_ticks", m_ticks, 12);
      chk("p1_akku", akku, 8'd44);
      chk("p1_ram22", u_dut.r_ram[22], 8'd44);
      chk("p1_ram21", u_dut.r_ram[21], 8'd200);

      // JMN taken/not taken, NOT, NAN, STV into next instruction, gated ticks
      ld(0, 8'h10); ld(1, 8'hA4); ld(2, 8'hE0); ld(3, 8'hE0);
      ld(4, 8'hC0); ld(5, 8'hA2); ld(6, 8'h71); ld(7, 8'h28);
      ld(16, 8'h80); ld(17, 8'h0F);
      run_prog(1, 1, 5'd8, 8'hC0);
      chk("p2_ticks", m_ticks, 21);
      chk("p2_akku", akku, 8'hF0);
      chk("p2_pc", pc, 9);
      chk("p2_ram8", u_dut.r_ram[8], 8'hF0);

      // pc wrap: sequential fetch at 31, then JMP 0 at 31
      ld(0, 8'hA3); ld(1, 8'h9E); ld(3, 8'hE0);
      ld(30, 8'hC0); ld(31, 8'h10);
      run_prog(0, 0, 5'd0, 8'h00);
      chk("p3a_ticks", m_ticks, 18);
      chk("p3a_pc", pc, 4);
      chk("p3a_akku", akku, 8'h80);
      ld(31, 8'h80);
      run_prog(1, 0, 5'd0, 8'h00);
      chk("p3b_ticks", m_ticks, 18);
      chk("p3b_pc", pc, 4);
      chk("p3b_akku", akku, 8'hFF);

      // reset while ADD is in EXECUTE
      ld(0, 8'h14); ld(1, 8'h55); ld(2, 8'h36); ld(3, 8'hE0);
      ld(22, 8'h11);
      start_core(0, 5'd0, 8'h00);
      repeat (5) cyc();
      @(negedge clk);
      #2 m_run = 0;
      chk("pre_rst_state", state, 3);
      chk("pre_rst_akku", akku, 8'd100);
      resetn = 0;
      #1;
      chk("mid_rst_state", state, 0);
      chk("mid_rst_akku", akku, 0);
      chk("mid_rst_pc", pc, 0);
      chk("mid_rst_ir", ir, 0);
      chk("mid_rst_ram22", u_dut.r_ram[22], 8'h11);
      chk("mid_rst_ram21", u_dut.r_ram[21], 8'd200);
      @(negedge clk);
      resetn = 1;
      repeat (6) @(negedge clk);
      chk("no_autostart", state, 0);
      m_acc = 0; m_pc = 0; m_ir = 0; m_halt = 0;

`ifdef UL8_STEP_EN
      step_mode = 1;
      start_core(0, 5'd0, 8'h00);
      m_run = 0;
      for (int k = 0; k < 4; k++) begin
         int w;
         m_exec();
         w = 0;
         while (!(state == 3'd4 || state == 3'd5) && w < 10) begin
            @(negedge clk);
            w++;
         end
         chk("step_stop", state, m_halt ? 32'd5 : 32'd4);
         chk("step_akku", akku, m_acc);
         chk("step_pc", pc, m_pc);
         if (!m_halt) begin
            @(posedge clk);
            #1 tick = 0; step = 1;
            @(negedge clk);
            chk("step_hold_t0", state, 4);
            @(posedge clk);
            #1 tick = 1; step = 0;
            @(negedge clk);
            chk("step_hold_s0", state, 4);
            chk("step_hold_pc", pc, m_pc);
            @(posedge clk);
            #1 step = 1;
            @(posedge clk);
            #1 step = 0;
         end
      end
      chk("step_ram22", u_dut.r_ram[22], 8'd44);
      step_mode = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
